my_crc_block: RTL and testbench
===============================

MY_CRC_BLOCK -- requirements
Module: my_crc

Interface
REQ-001 The module SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  2  Avalon-MM word address.
REQ-005 read  input  1  read strobe, qualified by chipselect.
REQ-006 write  input  1  write strobe, qualified by chipselect.
REQ-007 chipselect  input  1  slave select; read/write ignored when low.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data.

Function
REQ-010 Register map SHALL be:
- addr 0: W = push 32-bit word; R = RESULT.
- addr 1: W = push byte writedata[7:0]; R = STATUS.
- addr 2: W = CTRL, bit0 = CLEAR, other bits ignored; R = raw CRC register.
- addr 3: W = ignored; R = COUNT.
REQ-011 STATUS SHALL read {28'b0, OVERFLOW[3], EMPTY[2], FULL[1], BUSY[0]}.
REQ-012 Pushes SHALL enter a 16-entry FIFO; each entry holds 32 data bits plus a 1-bit word/byte type.
REQ-013 Back-to-back pushes every cycle SHALL be accepted while FIFO is not full.
REQ-014 Push when FULL SHALL be dropped and SHALL set sticky OVERFLOW.
REQ-015 Simultaneous push and pop on a full FIFO SHALL accept the push.
REQ-016 The engine SHALL consume one byte per cycle: a word entry takes 4 cycles, bits [7:0] first through [31:24]; a byte entry takes 1 cycle.
REQ-017 The engine SHALL pop the next entry in the cycle after the previous one finishes; no idle gap.
REQ-018 CRC SHALL use polynomial 0x04C11DB7 and init 0xFFFFFFFF; the 32-bit CRC register updates one byte per cycle.
REQ-019 COUNT SHALL increment by 1 per byte consumed and wrap modulo 2^32.
REQ-020 BUSY SHALL be 1 while the FIFO is non-empty or the engine is mid-entry.
REQ-021 RESULT SHALL be the finalized CRC of the current register; reading while BUSY returns the intermediate value.
REQ-022 read & chipselect SHALL load readdata on the next rising edge (1-cycle latency); otherwise readdata SHALL hold its value.
REQ-023 Read and write in the same cycle SHALL both take effect; the read returns pre-write state.
REQ-024 CLEAR SHALL, on the next edge, flush the FIFO, abort the engine, restore the CRC register to init, and zero COUNT and OVERFLOW; this holds even mid-operation.

Reset
REQ-025 On reset: readdata = 0, CRC register = 0xFFFFFFFF, COUNT = 0, FIFO empty, engine idle, OVERFLOW = 0.
REQ-026 Reset SHALL take precedence over any simultaneous read or write.

Configuration
REQ-027 Macro MY_CRC_REFLECT_EN defined: each input byte is processed LSB-first (reflected), and RESULT = bit-reversed register XOR 0xFFFFFFFF (CRC-32/ISO-HDLC).
REQ-028 MY_CRC_REFLECT_EN undefined: bytes are processed MSB-first, and RESULT = register unmodified (CRC-32/MPEG-2).
REQ-029 The raw CRC register (addr 2) SHALL be unaffected by the macro's output transform.

Verification
REQ-030 Reset, then read addr1 and addr0 -> STATUS = 0x00000004; RESULT = 0x00000000 (macro) or 0xFFFFFFFF (no macro).
REQ-031 Write addr0 0x34333231, addr0 0x38373635, addr1 0x39; poll until BUSY = 0 -> RESULT = 0xCBF43926 (macro) or 0x0376E6E7 (no macro); COUNT = 9.
REQ-032 12 back-to-back addr0 writes, 0x0E1B2C54 through 0x00EBD51B -> OVERFLOW = 0; BUSY clears no more than 50 cycles after the last write; COUNT = 48.
REQ-033 24 back-to-back addr0 writes -> FULL seen, OVERFLOW = 1; after drain, COUNT is a multiple of 4 and < 96.
REQ-034 Write CLEAR mid-stream -> next cycle STATUS = 0x00000004, COUNT = 0, raw CRC = 0xFFFFFFFF.
REQ-035 Assert reset mid-stream for 1 cycle -> all REQ-025 values; a following push sequence gives the same result as from power-up.

Source files
------------

// File: rtl/my_crc_block.sv
// Avalon-MM CRC-32 engine: 16-entry push FIFO feeding a byte-per-cycle CRC (poly 0x04C11DB7).
// Define MY_CRC_REFLECT_EN for CRC-32/ISO-HDLC; leave undefined for CRC-32/MPEG-2.
module my_crc_block (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic        chipselect,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] din);
        logic [31:0] c;
        c = crc ^ {din, 24'h00_0000};
        for (int i = 0; i < 8; i++) begin
            if (c[31]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Entry layout: bit 32 = word (1) / byte (0), bits 31:0 = payload.
    logic [32:0] fifo_mem_q [16];
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]  fifo_cnt_q, fifo_cnt_d;
    logic        active_q, active_d;
    logic [31:0] cur_data_q, cur_data_d;
    logic        cur_word_q, cur_word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [31:0] readdata_q, readdata_d;

    logic        wr_en_s, rd_en_s, push_s, clear_s;
    logic        empty_s, full_s, busy_s, last_byte_s, pop_s, push_ok_s, drop_s;
    logic [7:0]  cur_byte_s, feed_byte_s;
    logic [31:0] crc_next_s, result_s, status_s, push_data_s;

    // Bus decode and FIFO/engine handshake conditions.
    always_comb begin
        wr_en_s     = chipselect & write;
        rd_en_s     = chipselect & read;
        push_s      = wr_en_s & ((address == 2'd0) | (address == 2'd1));
        clear_s     = wr_en_s & (address == 2'd2) & writedata[0];
        empty_s     = (fifo_cnt_q == 5'd0);
        full_s      = (fifo_cnt_q == 5'd16);
        busy_s      = ~empty_s | active_q;
        last_byte_s = active_q & (~cur_word_q | (byte_idx_q == 2'd3));
        // Popping in the last-byte cycle keeps the engine gap-free.
        pop_s       = ~empty_s & (~active_q | last_byte_s);
        push_ok_s   = push_s & (~full_s | pop_s);
        drop_s      = push_s & full_s & ~pop_s;
        if (address == 2'd0) begin
            push_data_s = writedata;
        end else begin
            push_data_s = {24'h00_0000, writedata[7:0]};
        end
    end

    // Byte selection and CRC datapath.
    always_comb begin
        case (byte_idx_q)
            2'd0:    cur_byte_s = cur_data_q[7:0];
            2'd1:    cur_byte_s = cur_data_q[15:8];
            2'd2:    cur_byte_s = cur_data_q[23:16];
            2'd3:    cur_byte_s = cur_data_q[31:24];
            default: cur_byte_s = 8'h00;
        endcase
`ifdef MY_CRC_REFLECT_EN
        feed_byte_s = bitrev8(cur_byte_s);
        result_s    = bitrev32(crc_q) ^ 32'hFFFF_FFFF;
`else
        feed_byte_s = cur_byte_s;
        result_s    = crc_q;
`endif
        crc_next_s = crc_step(crc_q, feed_byte_s);
        status_s   = {28'h000_0000, ovf_q, empty_s, full_s, busy_s};
    end

    // Next-state logic for FIFO pointers, engine, CRC, counters and read data.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        active_d   = active_q;
        cur_data_d = cur_data_q;
        cur_word_d = cur_word_q;
        byte_idx_d = byte_idx_q;
        crc_d      = crc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        readdata_d = readdata_q;

        if (clear_s) begin
            wr_ptr_d   = 4'd0;
            rd_ptr_d   = 4'd0;
            fifo_cnt_d = 5'd0;
            active_d   = 1'b0;
            byte_idx_d = 2'd0;
            crc_d      = CRC_INIT;
            count_d    = 32'd0;
            ovf_d      = 1'b0;
        end else begin
            if (active_q) begin
                crc_d      = crc_next_s;
                count_d    = count_q + 32'd1;
                byte_idx_d = byte_idx_q + 2'd1;
            end else begin
                crc_d = crc_q;
            end
            if (pop_s) begin
                cur_data_d = fifo_mem_q[rd_ptr_q][31:0];
                cur_word_d = fifo_mem_q[rd_ptr_q][32];
                byte_idx_d = 2'd0;
                active_d   = 1'b1;
                rd_ptr_d   = rd_ptr_q + 4'd1;
            end else if (last_byte_s) begin
                active_d = 1'b0;
            end else begin
                active_d = active_q;
            end
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + 4'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 5'd1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 5'd1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
            if (drop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end

        // Reads sample current (pre-write) state.
        if (rd_en_s) begin
            case (address)
                2'd0:    readdata_d = result_s;
                2'd1:    readdata_d = status_s;
                2'd2:    readdata_d = crc_q;
                2'd3:    readdata_d = count_q;
                default: readdata_d = 32'd0;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= 4'd0;
            rd_ptr_q   <= 4'd0;
            fifo_cnt_q <= 5'd0;
            active_q   <= 1'b0;
            cur_data_q <= 32'd0;
            cur_word_q <= 1'b0;
            byte_idx_q <= 2'd0;
            crc_q      <= CRC_INIT;
            count_q    <= 32'd0;
            ovf_q      <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            active_q   <= active_d;
            cur_data_q <= cur_data_d;
            cur_word_q <= cur_word_d;
            byte_idx_q <= byte_idx_d;
            crc_q      <= crc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
        end
    end

    // FIFO storage; contents are don't-care while the entry count says empty.
    always_ff @(posedge clk) begin
        if (!reset && push_ok_s) begin
            fifo_mem_q[wr_ptr_q] <= {(address == 2'd0), push_data_s};
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_my_crc_block.sv
// Directed self-checking bench for my_crc_block (honours MY_CRC_REFLECT_EN).
module tb_my_crc_block;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        chipselect = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;

    int total = 0;
    int bad = 0;

`ifdef MY_CRC_REFLECT_EN
    localparam logic [31:0] RES_INIT  = 32'h0000_0000;
    localparam logic [31:0] RES_CHECK = 32'hCBF4_3926;
    localparam logic [31:0] RAW_CHECK = 32'h9B63_D02C;
`else
    localparam logic [31:0] RES_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] RES_CHECK = 32'h0376_E6E7;
    localparam logic [31:0] RAW_CHECK = 32'h0376_E6E7;
`endif

    logic [31:0] vec12 [12] = '{32'h0E1B_2C54, 32'h1D36_5A8A, 32'h2C51_88C0, 32'h3B6C_B6F6,
                                32'h4A87_E42C, 32'h59A3_1262, 32'h68BE_4098, 32'h77D9_6ECE,
                                32'h86F4_9C04, 32'h950F_CA3A, 32'hA42A_F870, 32'h00EB_D51B};

    my_crc_block dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .write      (write),
        .chipselect (chipselect),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        write = 1'b0; chipselect = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        read = 1'b0; chipselect = 1'b0;
        d = readdata;
    endtask

    task automatic wait_idle(input int budget, output int n);
        logic [31:0] st;
        n = 0;
        st = 32'd1;
        while (st[0] && n < budget) begin
            rd(2'd1, st);
            n++;
        end
        total++;
        assert (!st[0]) else begin
            bad++;
            $error("FAIL idle_timeout: busy=%0d after %0d polls, expected busy=0", st[0], n);
        end
    endtask

    // Independent reference: classic table-free CRC in the final output domain.
    function automatic logic [31:0] ref_crc12();
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int w = 0; w < 12; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = vec12[w][8*k +: 8];
`ifdef MY_CRC_REFLECT_EN
                c = c ^ {24'h00_0000, b};
                for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
`else
                c = c ^ {b, 24'h00_0000};
                for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
`endif
            end
        end
`ifdef MY_CRC_REFLECT_EN
        return c ^ 32'hFFFF_FFFF;
`else
        return c;
`endif
    endfunction

    initial begin
        logic [31:0] d;
        int n;

        // Power-up reset
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_readdata", readdata, 32'd0);
        rd(2'd1, d); check("rst_status", d, 32'h0000_0004);
        rd(2'd0, d); check("rst_result", d, RES_INIT);
        rd(2'd2, d); check("rst_raw", d, 32'hFFFF_FFFF);
        rd(2'd3, d); check("rst_count", d, 32'd0);

        // chipselect low: write and read both ignored, readdata holds
        address = 2'd0; writedata = 32'h1234_5678; write = 1'b1; read = 1'b1; chipselect = 1'b0;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        check("cs_low_hold", readdata, 32'd0);
        rd(2'd1, d); check("cs_low_status", d, 32'h0000_0004);

        // "123456789" as two words plus one byte
        wr(2'd0, 32'h3433_3231);
        wr(2'd0, 32'h3837_3635);
        wr(2'd1, 32'h0000_0039);
        rd(2'd1, d); check("busy_set", {31'd0, d[0]}, 32'd1);
        wait_idle(40, n);
        rd(2'd0, d); check("check_result", d, RES_CHECK);
        rd(2'd3, d); check("check_count", d, 32'd9);

        // Read raw CRC while writing CLEAR in the same cycle: read sees pre-clear state
        address = 2'd2; writedata = 32'h0000_0001; read = 1'b1; write = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        read = 1'b0; write = 1'b0; chipselect = 1'b0;
        check("rw_same_cycle_raw", readdata, RAW_CHECK);
        rd(2'd3, d); check("after_clear_count", d, 32'd0);
        rd(2'd2, d); check("after_clear_raw", d, 32'hFFFF_FFFF);

        // 12 back-to-back words
        for (int i = 0; i < 12; i++) wr(2'd0, vec12[i]);
        wait_idle(50, n);
        rd(2'd1, d); check("b2b12_status", d, 32'h0000_0004);
        rd(2'd3, d); check("b2b12_count", d, 32'd48);
        rd(2'd0, d); check("b2b12_result", d, ref_crc12());

        // CTRL write with bit0 clear does nothing
        wr(2'd2, 32'hFFFF_FFFE);
        rd(2'd3, d); check("ctrl_noclear_count", d, 32'd48);

        // 24 back-to-back words: overflow
        wr(2'd2, 32'hFFFF_FFF1);
        for (int i = 0; i < 24; i++) wr(2'd0, 32'hA5A5_0000 + i);
        rd(2'd1, d); check("ovf_full_seen", d & 32'h0000_000A, 32'h0000_000A);
        wait_idle(120, n);
        rd(2'd1, d); check("ovf_status_drained", d, 32'h0000_000C);
        rd(2'd3, d);
        check("ovf_count_mod4", {30'd0, d[1:0]}, 32'd0);
        check("ovf_count_lt96", {31'd0, (d < 32'd96)}, 32'd1);
        check("ovf_count_nonzero", {31'd0, (d != 32'd0)}, 32'd1);

        // CLEAR mid-stream
        for (int i = 0; i < 4; i++) wr(2'd0, 32'h0101_0101 * (i + 1));
        wr(2'd2, 32'h0000_0001);
        rd(2'd1, d); check("clear_status", d, 32'h0000_0004);
        rd(2'd3, d); check("clear_count", d, 32'd0);
        rd(2'd2, d); check("clear_raw", d, 32'hFFFF_FFFF);

        // Reset mid-stream with a simultaneous read and write
        for (int i = 0; i < 3; i++) wr(2'd0, 32'hDEAD_BEE0 + i);
        reset = 1'b1; address = 2'd0; writedata = 32'h5555_5555;
        read = 1'b1; write = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        reset = 1'b0; read = 1'b0; write = 1'b0; chipselect = 1'b0;
        check("mid_rst_readdata", readdata, 32'd0);
        rd(2'd1, d); check("mid_rst_status", d, 32'h0000_0004);
        rd(2'd3, d); check("mid_rst_count", d, 32'd0);
        rd(2'd2, d); check("mid_rst_raw", d, 32'hFFFF_FFFF);
        rd(2'd0, d); check("mid_rst_result", d, RES_INIT);

        // Same sequence after reset; byte push ignores writedata[31:8]
        wr(2'd0, 32'h3433_3231);
        wr(2'd0, 32'h3837_3635);
        wr(2'd1, 32'hAABB_CC39);
        wait_idle(40, n);
        rd(2'd0, d); check("post_rst_result", d, RES_CHECK);
        rd(2'd3, d); check("post_rst_count", d, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
